ifc_txn_sequencer: RTL and testbench

- Upstream command stage for the 8-entry, 1-bit register interface (write_address/write_data/write_en/write_rdy, read_address/read_en/read_data/read_rdy).
- Buffers incoming read/write commands in a small FIFO and issues them one at a time on the interface, holding each enable until the matching ready is seen.
- Returns one response per command on a valid/ready port; read responses carry the captured read_data.

---
 rtl/ifc_txn_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ifc_txn_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifc_txn_sequencer.sv
// ifc_txn_sequencer: command FIFO plus single-outstanding sequencer for the
// 8-entry, 1-bit register interface. Each buffered read/write is issued with
// its enable held until the matching ready. One response per command comes
// back on a valid/ready port, in acceptance order.
// Optional build macro: IFC_TXN_TIMEOUT_EN. When defined, a stalled enable is
// dropped after TIMEOUT cycles and the response is flagged with rsp_err.
module ifc_txn_sequencer #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 3,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_data,
   output logic [ADDR_W-1:0] write_address,
   output logic              write_data,
   output logic              write_en,
   input  logic              write_rdy,
   output logic [ADDR_W-1:0] read_address,
   output logic              read_en,
   input  logic              read_rdy,
   input  logic              read_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_op,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   // Reject configurations that break pointer wrap or the timeout compare.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("ifc_txn_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2,
      S_RSP  = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Command FIFO storage
   logic [DEPTH-1:0]             fifo_op;
   logic [DEPTH-1:0]             fifo_data;
   logic [DEPTH-1:0][ADDR_W-1:0] fifo_addr;
   logic [PTR_W-1:0]             wr_ptr, rd_ptr;
   logic [CNT_W-1:0]             count;

   // Command currently on the interface / being responded to
   logic              cur_op;
   logic              cur_data;
   logic [ADDR_W-1:0] cur_addr;
   logic              rsp_data_q;

   logic push, pop;
   logic wr_ok, rd_ok;
   logic tmo_hit;

   // No bypass: acceptance depends on occupancy alone.
   assign cmd_ready = (count < CNT_W'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == S_IDLE) && (count != '0);

   // Ready only matters while the matching enable is up.
   assign wr_ok = (state_q == S_WR) && write_rdy;
   assign rd_ok = (state_q == S_RD) && read_rdy;

`ifdef IFC_TXN_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             rsp_err_q;

   // A ready in the final cycle wins, so the hit only matters when ready is low.
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

   // Stall counter: cleared on issue, counts cycles the pending ready stays low.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tmo_cnt <= '0;
      end else if (pop) begin
         tmo_cnt <= '0;
      end else if ((state_q == S_WR && !write_rdy) || (state_q == S_RD && !read_rdy)) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // Error flag: cleared on issue, set when a stalled enable is abandoned.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rsp_err_q <= 1'b0;
      end else if (pop) begin
         rsp_err_q <= 1'b0;
      end else if ((state_q == S_WR && !write_rdy && tmo_hit) ||
                   (state_q == S_RD && !read_rdy && tmo_hit)) begin
         rsp_err_q <= 1'b1;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign tmo_hit = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fifo_op   <= '0;
         fifo_data <= '0;
         fifo_addr <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         if (push) begin
            fifo_op[wr_ptr]   <= cmd_op;
            fifo_data[wr_ptr] <= cmd_data;
            fifo_addr[wr_ptr] <= cmd_addr;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Occupancy count; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: one command in flight, response must drain before the next pop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (pop)               state_d = fifo_op[rd_ptr] ? S_RD : S_WR;
         S_WR:   if (wr_ok || tmo_hit)  state_d = S_RSP;
         S_RD:   if (rd_ok || tmo_hit)  state_d = S_RSP;
         S_RSP:  if (rsp_ready)         state_d = S_IDLE;
         default:                       state_d = S_IDLE;
      endcase
   end

   // Capture the popped command and the response data it produces.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cur_op     <= 1'b0;
         cur_data   <= 1'b0;
         cur_addr   <= '0;
         rsp_data_q <= 1'b0;
      end else if (pop) begin
         cur_op     <= fifo_op[rd_ptr];
         cur_data   <= fifo_data[rd_ptr];
         cur_addr   <= fifo_addr[rd_ptr];
         rsp_data_q <= 1'b0;
      end else if (rd_ok) begin
         rsp_data_q <= read_data;
      end else if (wr_ok || ((state_q == S_WR || state_q == S_RD) && tmo_hit)) begin
         rsp_data_q <= 1'b0;
      end
   end

   // Interface and response outputs are decoded straight from flops.
   assign write_en      = (state_q == S_WR);
   assign read_en       = (state_q == S_RD);
   assign rsp_valid     = (state_q == S_RSP);
   assign write_address = cur_addr;
   assign write_data    = cur_data;
   assign read_address  = cur_addr;
   assign rsp_op        = cur_op;
   assign rsp_addr      = cur_addr;
   assign rsp_data      = rsp_data_q;
   assign busy          = (state_q != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_ifc_txn_sequencer.sv
// Directed bench for ifc_txn_sequencer: a vector table of write/read-back
// commands, plus hand sequences for stall, FIFO full, response backpressure,
// timeout (when IFC_TXN_TIMEOUT_EN is defined) and reset mid-read.
module tb_ifc_txn_sequencer;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic       cmd_op = 1'b0;
   logic [2:0] cmd_addr = '0;
   logic       cmd_data = 1'b0;
   logic [2:0] write_address, read_address, rsp_addr;
   logic       write_data, write_en, write_rdy, read_en, read_rdy, read_data;
   logic       rsp_valid, rsp_ready = 1'b0, rsp_op, rsp_data, rsp_err, busy;

   logic       wr_rdy_ctl = 1'b1;
   logic       rd_rdy_ctl = 1'b1;
   logic [7:0] mem = '0;

   int vec_cnt = 0;
   int miss_cnt = 0;
   int wen_cycles = 0, ren_cycles = 0, rsp_seen = 0, both_high = 0;

   always #5 CLK = ~CLK;

   ifc_txn_sequencer dut (
      .CLK(CLK), .RST_N(RST_N),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .write_address(write_address), .write_data(write_data),
      .write_en(write_en), .write_rdy(write_rdy),
      .read_address(read_address), .read_en(read_en),
      .read_rdy(read_rdy), .read_data(read_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy)
   );

   // Register-file model on the far side of the interface.
   assign write_rdy = wr_rdy_ctl;
   assign read_rdy  = rd_rdy_ctl;
   assign read_data = mem[read_address];

   always @(posedge CLK) begin
      if (write_en && write_rdy) mem[write_address] <= write_data;
   end

   // Activity monitors sampled away from the active edge.
   always @(negedge CLK) begin
      if (write_en) wen_cycles++;
      if (read_en) ren_cycles++;
      if (rsp_valid) rsp_seen++;
      if (write_en && read_en) both_high++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic op, input logic [2:0] a, input logic d);
      int k = 0;
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
      while (!cmd_ready && k < 100) begin @(negedge CLK); k++; end
      if (!cmd_ready) chk("push_wait_timeout", 32'd0, 32'd1);
      @(negedge CLK);
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input string nm, input logic op, input logic [2:0] a,
                          input logic d, input logic e);
      int k = 0;
      while (!rsp_valid && k < 100) begin @(negedge CLK); k++; end
      if (!rsp_valid) begin
         chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
         return;
      end
      chk({nm, "_op"},   32'(rsp_op),   32'(op));
      chk({nm, "_addr"}, 32'(rsp_addr), 32'(a));
      chk({nm, "_data"}, 32'(rsp_data), 32'(d));
      chk({nm, "_err"},  32'(rsp_err),  32'(e));
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
   endtask

   task automatic wait_sig(input string nm, input logic want_wr);
      int k = 0;
      while (!(want_wr ? write_en : read_en) && k < 100) begin @(negedge CLK); k++; end
      if (!(want_wr ? write_en : read_en)) chk({nm, "_en_timeout"}, 32'd0, 32'd1);
   endtask

   typedef struct {
      logic       op;
      logic [2:0] addr;
      logic       data;
      logic       exp_data;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int w0, r0, s0, k;

      tbl[0] = '{1'b0, 3'd5, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 3'd5, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 3'd2, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 3'd2, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 3'd7, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 3'd7, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 3'd0, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 3'd0, 1'b0, 1'b1};
      tbl[8] = '{1'b1, 3'd3, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_write_en",  32'(write_en),  32'd0);
      chk("rst_read_en",   32'(read_en),   32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_wr_addr",   32'(write_address), 32'd0);
      RST_N = 1'b1;

      // Table: write then read back, enable high exactly one cycle each
      for (int i = 0; i < 9; i++) begin
         w0 = wen_cycles; r0 = ren_cycles;
         push(tbl[i].op, tbl[i].addr, tbl[i].data);
         get_rsp($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].exp_data, 1'b0);
         if (tbl[i].op) chk($sformatf("vec%0d_ren_cycles", i), 32'(ren_cycles - r0), 32'd1);
         else           chk($sformatf("vec%0d_wen_cycles", i), 32'(wen_cycles - w0), 32'd1);
      end
      chk("idle_busy", 32'(busy), 32'd0);

      // Ready stall: write_rdy low 4 cycles, enable high 5
      wr_rdy_ctl = 1'b0;
      w0 = wen_cycles;
      push(1'b0, 3'd3, 1'b1);
      wait_sig("stall", 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("stall_addr",  32'(write_address), 32'd3);
         chk("stall_data",  32'(write_data),    32'd1);
         chk("stall_rspv",  32'(rsp_valid),     32'd0);
         @(negedge CLK);
      end
      wr_rdy_ctl = 1'b1;
      get_rsp("stall", 1'b0, 3'd3, 1'b0, 1'b0);
      chk("stall_wen_cycles", 32'(wen_cycles - w0), 32'd5);

      // FIFO full: responses held off, 6 offered, 5 accepted
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         cmd_valid = 1'b1;
         case (i)
            0: begin cmd_op = 1'b0; cmd_addr = 3'd1; cmd_data = 1'b1; end
            1: begin cmd_op = 1'b1; cmd_addr = 3'd1; cmd_data = 1'b0; end
            2: begin cmd_op = 1'b0; cmd_addr = 3'd4; cmd_data = 1'b1; end
            3: begin cmd_op = 1'b1; cmd_addr = 3'd4; cmd_data = 1'b0; end
            4: begin cmd_op = 1'b1; cmd_addr = 3'd5; cmd_data = 1'b0; end
            default: begin cmd_op = 1'b0; cmd_addr = 3'd6; cmd_data = 1'b1; end
         endcase
         chk($sformatf("full_cmd_ready%0d", i), 32'(cmd_ready), (i < 5) ? 32'd1 : 32'd0);
      end
      @(negedge CLK);
      cmd_valid = 1'b0;
      chk("full_held", 32'(cmd_ready), 32'd0);
      get_rsp("full0", 1'b0, 3'd1, 1'b0, 1'b0);
      get_rsp("full1", 1'b1, 3'd1, 1'b1, 1'b0);
      get_rsp("full2", 1'b0, 3'd4, 1'b0, 1'b0);
      get_rsp("full3", 1'b1, 3'd4, 1'b1, 1'b0);
      get_rsp("full4", 1'b1, 3'd5, 1'b1, 1'b0);
      s0 = rsp_seen;
      repeat (6) @(negedge CLK);
      chk("full_no_extra_rsp", 32'(rsp_seen - s0), 32'd0);
      chk("full_cmd_ready_back", 32'(cmd_ready), 32'd1);
      chk("full_busy_clear", 32'(busy), 32'd0);
      chk("full_refused_not_written", 32'(mem[6]), 32'd0);

      // Response backpressure: response held, queued command waits
      push(1'b1, 3'd7, 1'b0);
      push(1'b0, 3'd2, 1'b1);
      k = 0;
      while (!rsp_valid && k < 100) begin @(negedge CLK); k++; end
      for (int i = 0; i < 3; i++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_data",  32'(rsp_data),  32'd1);
         chk("bp_no_enable", 32'(write_en | read_en), 32'd0);
         @(negedge CLK);
      end
      get_rsp("bp0", 1'b1, 3'd7, 1'b1, 1'b0);
      get_rsp("bp1", 1'b0, 3'd2, 1'b0, 1'b0);

`ifdef IFC_TXN_TIMEOUT_EN
      // Timeout: read_rdy never comes, enable dropped after 15 cycles
      rd_rdy_ctl = 1'b0;
      r0 = ren_cycles;
      push(1'b1, 3'd4, 1'b0);
      push(1'b0, 3'd6, 1'b1);
      wait_sig("tmo", 1'b0);
      k = 0;
      while (read_en && k < 40) begin @(negedge CLK); k++; end
      chk("tmo_dropped", 32'(read_en), 32'd0);
      chk("tmo_ren_cycles", 32'(ren_cycles - r0), 32'd15);
      get_rsp("tmo", 1'b1, 3'd4, 1'b0, 1'b1);
      rd_rdy_ctl = 1'b1;
      get_rsp("tmo_next", 1'b0, 3'd6, 1'b0, 1'b0);
`else
      // No timeout: a stalled read waits indefinitely
      rd_rdy_ctl = 1'b0;
      push(1'b1, 3'd4, 1'b0);
      wait_sig("notmo", 1'b0);
      repeat (20) @(negedge CLK);
      chk("notmo_still_en", 32'(read_en), 32'd1);
      chk("notmo_no_rsp", 32'(rsp_valid), 32'd0);
      rd_rdy_ctl = 1'b1;
      get_rsp("notmo", 1'b1, 3'd4, 1'b1, 1'b0);
`endif

      // Reset mid-read: in-flight and queued commands discarded
      rd_rdy_ctl = 1'b0;
      push(1'b1, 3'd2, 1'b0);
      push(1'b0, 3'd5, 1'b0);
      wait_sig("rst", 1'b0);
      #2 RST_N = 1'b0;
      #1;
      chk("rst_mid_read_en",   32'(read_en),   32'd0);
      chk("rst_mid_write_en",  32'(write_en),  32'd0);
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_mid_busy",      32'(busy),      32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      rd_rdy_ctl = 1'b1;
      s0 = rsp_seen; w0 = wen_cycles; r0 = ren_cycles;
      repeat (10) @(negedge CLK);
      chk("rst_no_stale_rsp", 32'(rsp_seen - s0), 32'd0);
      chk("rst_no_stale_en",  32'((wen_cycles - w0) + (ren_cycles - r0)), 32'd0);
      push(1'b1, 3'd5, 1'b0);
      get_rsp("post_rst", 1'b1, 3'd5, 1'b1, 1'b0);

      chk("never_both_enables", 32'(both_high), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   // Absolute run-time bound.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
